// File: rtl/vec_mul_seq_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vec_mul_seq_ctrl
//
// Sequencer for the 1x64 vector-multiply datapath
// (Unified Buffer -> Weight FIFO -> vec_mul_1x64 -> SRAM_Results).
//
// A run is requested with start while IDLE. The controller then:
//   1. pops one weight set from the Weight FIFO (waiting while it is empty),
//   2. pulses weight_reload so the array latches the new weights,
//   3. issues num_vec consecutive UB read addresses starting at base_addr,
//   4. times the matching SRAM_Results writes through a PIPE_LATENCY-deep
//      valid delay line,
//   5. pulses end_ in the cycle after the final result write.
//
// Every output is a flop. Output registers are loaded from the next-state
// decode, so each output is aligned with the state it belongs to.
//
// Optional feature (macro CTRL_CYCLE_COUNT_EN):
//   adds output cycle_count, which reads 1 in the first busy cycle and
//   counts every busy cycle after that, saturating at 2^CNT_BW-1 and holding
//   its final value in IDLE until the next accepted start.
//
// Ports
//   clk               in   1            rising-edge clock
//   rstn              in   1            asynchronous active-low reset
//   start             in   1            run request, sampled in IDLE only
//   base_addr         in   ADDRESSSIZE  first UB address (captured on start)
//   num_vec           in   ADDRESSSIZE  vector count (captured on start)
//   fifo_empty        in   1            Weight FIFO empty flag
//   fifo_read_enable  out  1            one-cycle Weight FIFO pop
//   weight_reload     out  1            one-cycle weight latch strobe
//   ub_address        out  ADDRESSSIZE  UB read address
//   ub_addr_valid     out  1            ub_address carries a live vector
//   res_write_enable  out  1            SRAM_Results write strobe
//   res_address       out  ADDRESSSIZE  SRAM_Results write address
//   busy              out  1            high in every state except IDLE
//   end_              out  1            one-cycle completion pulse
//   cycle_count       out  CNT_BW       busy-cycle counter (optional)
// -----------------------------------------------------------------------------
module vec_mul_seq_ctrl #(
    parameter int ADDRESSSIZE  = 10,
    parameter int PIPE_LATENCY = 9
`ifdef CTRL_CYCLE_COUNT_EN
    ,
    parameter int CNT_BW       = 16
`endif
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [ADDRESSSIZE-1:0] base_addr,
    input  logic [ADDRESSSIZE-1:0] num_vec,
    input  logic                   fifo_empty,
    output logic                   fifo_read_enable,
    output logic                   weight_reload,
    output logic [ADDRESSSIZE-1:0] ub_address,
    output logic                   ub_addr_valid,
    output logic                   res_write_enable,
    output logic [ADDRESSSIZE-1:0] res_address,
    output logic                   busy,
    output logic                   end_
`ifdef CTRL_CYCLE_COUNT_EN
    ,
    output logic [CNT_BW-1:0]      cycle_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WLOAD,
        S_WRELOAD,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    w_accept;

    logic [ADDRESSSIZE-1:0]  r_base;
    logic [ADDRESSSIZE-1:0]  r_num;
    // Number of UB addresses already issued in the current run.
    logic [ADDRESSSIZE-1:0]  r_idx;

    logic                    r_fifo_re;
    logic                    r_reload;
    logic [ADDRESSSIZE-1:0]  r_ub_addr;
    logic                    r_ub_valid;
    logic [PIPE_LATENCY-1:0] r_line;
    logic [PIPE_LATENCY-1:0] w_line_next;
    logic                    w_pending;
    logic [ADDRESSSIZE-1:0]  r_res_addr;
    logic                    r_busy;
    logic                    r_end;

    // Delay line content after the coming edge. Bit 0 is fed by the current
    // ub_addr_valid; the top bit falls out as res_write_enable.
    assign w_line_next = (r_line << 1) | PIPE_LATENCY'(r_ub_valid);
    // DRAIN may finish once nothing is left in flight after this edge, which
    // makes the DONE cycle the one right after the final write.
    assign w_pending   = |w_line_next;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------------
    // NOTE: defaults are assigned first so no path leaves a signal unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next   = S_WLOAD;
                    w_accept = 1'b1;
                end
            end
            S_WLOAD: begin
                // The pop is decided on the edge that first sees the FIFO
                // non-empty; the pop cycle itself is the last WLOAD cycle.
                if (r_fifo_re) begin
                    w_next = S_WRELOAD;
                end
            end
            S_WRELOAD: begin
                w_next = (r_num == '0) ? S_DONE : S_STREAM;
            end
            S_STREAM: begin
                if (r_idx == r_num) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!w_pending) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                // start is deliberately not looked at here.
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registered outputs and run datapath
    // ------------------------------------------------------------------------
    // NOTE: the valid delay line is reset together with the control flops so
    // a run abandoned by reset cannot emit stray result writes afterwards.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_base     <= '0;
            r_num      <= '0;
            r_idx      <= '0;
            r_fifo_re  <= 1'b0;
            r_reload   <= 1'b0;
            r_ub_addr  <= '0;
            r_ub_valid <= 1'b0;
            r_line     <= '0;
            r_res_addr <= '0;
            r_busy     <= 1'b0;
            r_end      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_base <= base_addr;
                r_num  <= num_vec;
            end

            // fifo_empty is ignored outside WLOAD.
            r_fifo_re  <= (w_next == S_WLOAD) && !fifo_empty;
            r_reload   <= (w_next == S_WRELOAD);
            r_ub_valid <= (w_next == S_STREAM);
            r_busy     <= (w_next != S_IDLE);
            r_end      <= (w_next == S_DONE);

            if (w_next == S_STREAM) begin
                if (r_state == S_STREAM) begin
                    // Address arithmetic wraps modulo 2^ADDRESSSIZE.
                    r_ub_addr <= r_base + r_idx;
                    r_idx     <= r_idx + 1'b1;
                end else begin
                    r_ub_addr <= r_base;
                    r_idx     <= ADDRESSSIZE'(1);
                end
            end

            r_line <= w_line_next;

            // res_address shows the target of the current write and advances
            // after it, so write k of a run lands at address k.
            if (w_accept) begin
                r_res_addr <= '0;
            end else if (r_line[PIPE_LATENCY-1]) begin
                r_res_addr <= r_res_addr + 1'b1;
            end
        end
    end

    assign fifo_read_enable = r_fifo_re;
    assign weight_reload    = r_reload;
    assign ub_address       = r_ub_addr;
    assign ub_addr_valid    = r_ub_valid;
    assign res_write_enable = r_line[PIPE_LATENCY-1];
    assign res_address      = r_res_addr;
    assign busy             = r_busy;
    assign end_             = r_end;

`ifdef CTRL_CYCLE_COUNT_EN
    // ------------------------------------------------------------------------
    // Busy-cycle counter
    // ------------------------------------------------------------------------
    logic [CNT_BW-1:0] r_cycle_count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cycle_count <= '0;
        end else if (w_accept) begin
            // Cleared on acceptance and counting the first busy cycle at once.
            r_cycle_count <= CNT_BW'(1);
        end else if ((w_next != S_IDLE) && (r_cycle_count != '1)) begin
            r_cycle_count <= r_cycle_count + 1'b1;
        end
    end

    assign cycle_count = r_cycle_count;
`endif

endmodule

// File: tb/tb_vec_mul_seq_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_vec_mul_seq_ctrl
//
// Directed bench for vec_mul_seq_ctrl. Each run is checked cycle by cycle
// against a timeline derived from base_addr, num_vec, the number of cycles
// the Weight FIFO stays empty, and PIPE_LATENCY:
//   cycle 1..W        WLOAD, no pop
//   cycle W+1         fifo_read_enable
//   cycle W+2         weight_reload
//   cycle S..S+N-1    ub_addr_valid, ub_address = base+(c-S)      (S = W+3)
//   cycle S+P..       res_write_enable, res_address = c-S-P
//   cycle D           end_  (D = S+N+P, or W+3 when N = 0)
// With CTRL_CYCLE_COUNT_EN a second instance with CNT_BW=4 covers saturation.
// -----------------------------------------------------------------------------
module tb_vec_mul_seq_ctrl;

    localparam int AW = 10;
    localparam int P  = 9;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] num_vec = '0;
    logic          fifo_empty = 1'b0;

    logic          fifo_read_enable;
    logic          weight_reload;
    logic [AW-1:0] ub_address;
    logic          ub_addr_valid;
    logic          res_write_enable;
    logic [AW-1:0] res_address;
    logic          busy;
    logic          end_;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

`ifdef CTRL_CYCLE_COUNT_EN
    logic [15:0]   cycle_count;
    logic [3:0]    sat_cycle_count;
    logic          sat_fifo_read_enable;
    logic          sat_weight_reload;
    logic [AW-1:0] sat_ub_address;
    logic          sat_ub_addr_valid;
    logic          sat_res_write_enable;
    logic [AW-1:0] sat_res_address;
    logic          sat_busy;
    logic          sat_end;
    int            exp_cnt = 0;
    int            exp_sat = 0;

    vec_mul_seq_ctrl #(
        .ADDRESSSIZE (AW),
        .PIPE_LATENCY(P),
        .CNT_BW      (16)
    ) u_dut (
        .clk             (clk),
        .rstn            (rstn),
        .start           (start),
        .base_addr       (base_addr),
        .num_vec         (num_vec),
        .fifo_empty      (fifo_empty),
        .fifo_read_enable(fifo_read_enable),
        .weight_reload   (weight_reload),
        .ub_address      (ub_address),
        .ub_addr_valid   (ub_addr_valid),
        .res_write_enable(res_write_enable),
        .res_address     (res_address),
        .busy            (busy),
        .end_            (end_),
        .cycle_count     (cycle_count)
    );

    vec_mul_seq_ctrl #(
        .ADDRESSSIZE (AW),
        .PIPE_LATENCY(P),
        .CNT_BW      (4)
    ) u_dut_sat (
        .clk             (clk),
        .rstn            (rstn),
        .start           (start),
        .base_addr       (base_addr),
        .num_vec         (num_vec),
        .fifo_empty      (fifo_empty),
        .fifo_read_enable(sat_fifo_read_enable),
        .weight_reload   (sat_weight_reload),
        .ub_address      (sat_ub_address),
        .ub_addr_valid   (sat_ub_addr_valid),
        .res_write_enable(sat_res_write_enable),
        .res_address     (sat_res_address),
        .busy            (sat_busy),
        .end_            (sat_end),
        .cycle_count     (sat_cycle_count)
    );
`else
    vec_mul_seq_ctrl #(
        .ADDRESSSIZE (AW),
        .PIPE_LATENCY(P)
    ) u_dut (
        .clk             (clk),
        .rstn            (rstn),
        .start           (start),
        .base_addr       (base_addr),
        .num_vec         (num_vec),
        .fifo_empty      (fifo_empty),
        .fifo_read_enable(fifo_read_enable),
        .weight_reload   (weight_reload),
        .ub_address      (ub_address),
        .ub_addr_valid   (ub_addr_valid),
        .res_write_enable(res_write_enable),
        .res_address     (res_address),
        .busy            (busy),
        .end_            (end_)
    );
`endif

    // Flag order: busy, pop, reload, ub valid, write enable, end_.
    function automatic logic [5:0] flags();
        return {busy, fifo_read_enable, weight_reload, ub_addr_valid,
                res_write_enable, end_};
    endfunction

    // Idle check at the coming falling edge; caller may already be driving
    // start, which cannot affect registered outputs in the same cycle.
    task automatic check_idle(input string name);
        @(negedge clk);
        vectors++;
        if (flags() !== 6'b0) begin
            miscompares++;
            $display("FAIL %s idle flags got=%b want=000000", name, flags());
        end
`ifdef CTRL_CYCLE_COUNT_EN
        vectors++;
        if (cycle_count !== 16'(exp_cnt) || sat_cycle_count !== 4'(exp_sat)) begin
            miscompares++;
            $display("FAIL %s idle cycle_count got=%0d/%0d want=%0d/%0d",
                     name, cycle_count, sat_cycle_count, exp_cnt, exp_sat);
        end
`endif
    endtask

    // One full run. Entered and left just after a rising edge with the DUT
    // idle; on return the DUT is in the cycle after DONE, so a following call
    // exercises a back-to-back start.
    task automatic run_check(input logic [AW-1:0] base, input logic [AW-1:0] nv,
                             input int w, input bit poke_start, input string name);
        int            s;
        int            d;
        logic [5:0]    exp_f;
        logic [AW-1:0] exp_a;
        s = w + 3;
        d = (nv == 0) ? w + 3 : s + int'(nv) + P;

        start      = 1'b1;
        base_addr  = base;
        num_vec    = nv;
        fifo_empty = (w > 0);
        check_idle({name, "/pre"});
        @(posedge clk); #1;
        // Changed inputs prove base_addr/num_vec were captured at acceptance.
        start     = 1'b0;
        base_addr = ~base;
        num_vec   = nv + 10'd3;

        for (int c = 1; c <= d; c++) begin
            fifo_empty = (c != w);
            if (poke_start && (c == s + 1 || c == d)) begin
                start     = 1'b1;
                base_addr = 10'd0;
                num_vec   = 10'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            exp_f[5] = 1'b1;
            exp_f[4] = (c == w + 1);
            exp_f[3] = (c == w + 2);
            exp_f[2] = (nv != 0) && (c >= s) && (c < s + int'(nv));
            exp_f[1] = (nv != 0) && (c >= s + P) && (c < s + P + int'(nv));
            exp_f[0] = (c == d);
            vectors++;
            if (flags() !== exp_f) begin
                miscompares++;
                $display("FAIL %s c=%0d flags got=%b want=%b", name, c, flags(), exp_f);
            end
            if (exp_f[2]) begin
                exp_a = base + AW'(c - s);
                vectors++;
                if (ub_address !== exp_a) begin
                    miscompares++;
                    $display("FAIL %s c=%0d ub_address got=%0d want=%0d",
                             name, c, ub_address, exp_a);
                end
            end
            if (exp_f[1]) begin
                exp_a = AW'(c - s - P);
                vectors++;
                if (res_address !== exp_a) begin
                    miscompares++;
                    $display("FAIL %s c=%0d res_address got=%0d want=%0d",
                             name, c, res_address, exp_a);
                end
            end
`ifdef CTRL_CYCLE_COUNT_EN
            if (c == d) begin
                vectors++;
                if (cycle_count !== 16'(d) || sat_cycle_count !== 4'((d > 15) ? 15 : d)) begin
                    miscompares++;
                    $display("FAIL %s cycle_count at end_ got=%0d/%0d want=%0d/%0d",
                             name, cycle_count, sat_cycle_count, d, (d > 15) ? 15 : d);
                end
            end
`endif
            @(posedge clk); #1;
        end
        start      = 1'b0;
        fifo_empty = 1'b0;
`ifdef CTRL_CYCLE_COUNT_EN
        exp_cnt = d;
        exp_sat = (d > 15) ? 15 : d;
`endif
    endtask

    task automatic test_reset();
        // Power-on reset.
        @(negedge clk);
        vectors++;
        if (flags() !== 6'b0 || ub_address !== '0 || res_address !== '0) begin
            miscompares++;
            $display("FAIL reset_por got flags=%b ub=%0d res=%0d want all 0",
                     flags(), ub_address, res_address);
        end
        #3 rstn = 1'b1;
        @(posedge clk); #1;

        // Start a run and abort it in the middle of STREAM (cycle 5).
        start      = 1'b1;
        base_addr  = 10'd16;
        num_vec    = 10'd8;
        fifo_empty = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        vectors++;
        if (ub_addr_valid !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_prerun got valid=%b busy=%b want 1 1",
                     ub_addr_valid, busy);
        end
        #1 rstn = 1'b0;
        #1;
        vectors++;
        if (flags() !== 6'b0 || ub_address !== '0 || res_address !== '0) begin
            miscompares++;
            $display("FAIL reset_midrun got flags=%b ub=%0d res=%0d want all 0",
                     flags(), ub_address, res_address);
        end
`ifdef CTRL_CYCLE_COUNT_EN
        exp_cnt = 0;
        exp_sat = 0;
`endif
        #1 rstn = 1'b1;
        // Abandoned run: stays idle, no end_ and no stray writes.
        for (int i = 0; i < 12; i++) begin
            check_idle("reset_after");
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        run_check(10'd16, 10'd8, 0, 1'b0, "basic");
        check_idle("basic_idle");
        @(posedge clk); #1;
    endtask

    task automatic test_empty_fifo();
        run_check(10'd100, 10'd3, 5, 1'b0, "empty_fifo");
        check_idle("empty_fifo_idle");
        @(posedge clk); #1;
    endtask

    task automatic test_wrap_and_zero();
        run_check(10'd1022, 10'd4, 0, 1'b0, "wrap");
        check_idle("wrap_idle");
        @(posedge clk); #1;
        run_check(10'd5, 10'd0, 0, 1'b0, "zero");
        check_idle("zero_idle");
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        // Starts pulsed in STREAM and in DONE are ignored; the next run
        // starts in the cycle after DONE with res_address back at 0.
        run_check(10'd40, 10'd6, 0, 1'b1, "busy_start");
        run_check(10'd200, 10'd2, 0, 1'b0, "back_to_back");
        check_idle("final_idle");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty_fifo();
        test_wrap_and_zero();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
